// File: rtl/cla_pipe_adder_if.sv
// Stream bundle for cla_pipe_adder: operand side, result side and their handshakes.
// The ovf result bit exists only when CLA_PIPE_OVF_EN is defined.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef CLA_PIPE_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, A, B, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out
`ifdef CLA_PIPE_OVF_EN
    , output ovf
`endif
  );

  modport master (
    output in_valid, A, B, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out
`ifdef CLA_PIPE_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one CLA slice per register stage, valid/ready on both sides.
// Optional signed-overflow output enabled by CLA_PIPE_OVF_EN.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  cla_pipe_adder_if.slave bus
);
  localparam int SLICE  = WIDTH / STAGES;
  localparam int NGROUP = SLICE / GROUP;

  // Returns {carry_out, sum}; group G/P give the carry across each group boundary.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             ci);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             gg;
    logic             gp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int j = 0; j < NGROUP; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        gp = gp & p[j*GROUP+i];
      end
      for (int i = 0; i < GROUP-1; i++)
        c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
      c[(j+1)*GROUP] = gg | (gp & c[j*GROUP]);
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];

  logic [WIDTH-1:0]  w_a      [STAGES];
  logic [WIDTH-1:0]  w_b      [STAGES];
  logic [WIDTH-1:0]  w_sum_in [STAGES];
  logic [WIDTH-1:0]  w_sum    [STAGES];
  logic [SLICE:0]    w_slice  [STAGES];
  logic [STAGES-1:0] w_ci;
  logic [STAGES-1:0] w_co;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_ready;

  always_comb begin : stage_logic
    w_ci = '0;
    w_co = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_a[k]      = '0;
      w_b[k]      = '0;
      w_sum_in[k] = '0;
      w_sum[k]    = '0;
      w_slice[k]  = '0;
    end
    // B is inverted once here; later stages only see B'.
    w_a[0]  = bus.A;
    w_b[0]  = bus.B ^ {WIDTH{bus.sub}};
    w_ci[0] = bus.c_in | bus.sub;
    for (int k = 1; k < STAGES; k++) begin
      w_a[k]      = r_a[k-1];
      w_b[k]      = r_b[k-1];
      w_sum_in[k] = r_sum[k-1];
      w_ci[k]     = r_carry[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_slice[k] = cla_slice(w_a[k][k*SLICE +: SLICE], w_b[k][k*SLICE +: SLICE], w_ci[k]);
      w_sum[k]   = w_sum_in[k];
      w_sum[k][k*SLICE +: SLICE] = w_slice[k][SLICE-1:0];
      w_co[k]    = w_slice[k][SLICE];
    end
  end

  assign w_vin = STAGES'({r_valid, bus.in_valid});

  // ready_k = ~valid_k | ready_{k+1}, unrolled so no vector feeds itself.
  always_comb begin : ready_chain
    logic run;
    run     = bus.out_ready;
    w_ready = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      run        = run | ~r_valid[k];
      w_ready[k] = run;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_carry <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_vin[k];
          r_a[k]     <= w_a[k];
          r_b[k]     <= w_b[k];
          r_sum[k]   <= w_sum[k];
          r_carry[k] <= w_co[k];
        end
      end
    end
  end

  assign bus.in_ready  = w_ready[0];
  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.sum       = r_sum[STAGES-1];
  assign bus.c_out     = r_carry[STAGES-1];

`ifdef CLA_PIPE_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Carry into the MSB is recovered from the MSB sum bit of the last slice.
  assign w_ovf = w_a[STAGES-1][WIDTH-1] ^ w_b[STAGES-1][WIDTH-1]
               ^ w_sum[STAGES-1][WIDTH-1] ^ w_co[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_ovf <= 1'b0;
    else if (w_ready[STAGES-1])  r_ovf <= w_ovf;
  end

  assign bus.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed cases on 32-bit/2- and 4-stage builds,
// plus randomized streams on three width/stage configurations against an arithmetic model.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_rnd;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rnd_done = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  cla_pipe_adder_if #(.WIDTH(32)) if2 ();
  cla_pipe_adder_if #(.WIDTH(32)) if4 ();

  cla_pipe_adder #(.WIDTH(32), .STAGES(2), .GROUP(4)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  cla_pipe_adder #(.WIDTH(32), .STAGES(4), .GROUP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic set_in(input int which, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb);
    if (which == 2) begin
      if2.in_valid = v; if2.A = a; if2.B = b; if2.c_in = ci; if2.sub = sb;
    end else begin
      if4.in_valid = v; if4.A = a; if4.B = b; if4.c_in = ci; if4.sub = sb;
    end
  endtask

  function automatic logic outv(input int which);
    return (which == 2) ? if2.out_valid : if4.out_valid;
  endfunction

  function automatic logic [33:0] obs(input int which);
    logic ov;
    ov = 1'b0;
`ifdef CLA_PIPE_OVF_EN
    ov = (which == 2) ? if2.ovf : if4.ovf;
`endif
    return (which == 2) ? {ov, if2.c_out, if2.sum} : {ov, if4.c_out, if4.sum};
  endfunction

  // One isolated operation: checks latency in cycles and the {ovf, c_out, sum} word.
  task automatic op(input string tag, input int which, input int exp_lat,
                    input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                    input logic [31:0] es, input logic ec, input logic eo);
    int          lat;
    logic [33:0] e;
    e = {eo, ec, es};
`ifndef CLA_PIPE_OVF_EN
    e[33] = 1'b0;
`endif
    @(negedge clk);
    set_in(which, 1'b1, a, b, ci, sb);
    lat = 0;
    do begin
      @(negedge clk);
      set_in(which, 1'b0, a, b, ci, sb);
      lat++;
    end while (!outv(which) && lat < 12);
    check_val({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check_val({tag, "_res"}, 128'(obs(which)), 128'(e));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] bp_a [6];
    logic [31:0] bp_b [6];
    int          j;
    int          got;
    int          extra;
    int          jj;

    rst = 1'b1;
    rst_rnd = 1'b1;
    set_in(2, 1'b0, '0, '0, 1'b0, 1'b0);
    set_in(4, 1'b0, '0, '0, 1'b0, 1'b0);
    if2.out_ready = 1'b1;
    if4.out_ready = 1'b1;

    @(negedge clk); #1;
    check_val("rst_out2",   128'(obs(2)), 128'(0));
    check_val("rst_out4",   128'(obs(4)), 128'(0));
    check_val("rst_ready2", 128'(if2.in_ready), 128'(1));
    check_val("rst_valid4", 128'(if4.out_valid), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rst_rnd = 1'b0;

    op("t1a", 2, 2, 32'ha000ffff, 32'h7000ffff, 1'b0, 1'b0, 32'h1001fffe, 1'b1, 1'b0);
    op("t1b", 2, 2, 32'ha000ffff, 32'h4000ffff, 1'b0, 1'b0, 32'he001fffe, 1'b0, 1'b0);
    op("t1c", 2, 2, 32'h4000ff00, 32'h4000ffff, 1'b0, 1'b0, 32'h8001feff, 1'b0, 1'b1);
    op("t2a", 2, 2, 32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);
    op("t2b", 2, 2, 32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hfffffffe, 1'b0, 1'b0);
    op("t2c", 2, 2, 32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
    op("t2d", 2, 2, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7fffffff, 1'b1, 1'b1);
    op("t3a", 4, 4, 32'h0000ffff, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
    op("t3b", 4, 4, 32'hffffffff, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    op("t3c", 2, 2, 32'hffffffff, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    op("t3d", 4, 4, 32'h7fffffff, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);

    // Backpressure: six back-to-back beats, output stalled for the first five cycles.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = $urandom;
      bp_b[i] = $urandom;
    end
    j = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      if2.out_ready = (cyc >= 5);
      jj = (j < 6) ? j : 5;
      set_in(2, j < 6, bp_a[jj], bp_b[jj], 1'b0, 1'b0);
      #1;
      if (cyc >= 2 && cyc <= 4)
        check_val("bp_hold", 128'({if2.out_valid, if2.sum}), 128'({1'b1, 32'(bp_a[0] + bp_b[0])}));
      if (cyc == 4) begin
        check_val("bp_in_ready", 128'(if2.in_ready), 128'(0));
        check_val("bp_accepted", 128'(j), 128'(2));
      end
      if (if2.out_valid && if2.out_ready) begin
        check_val("bp_data", 128'(if2.sum), 128'(32'(bp_a[got] + bp_b[got])));
        got++;
      end
      if (if2.in_valid && if2.in_ready) j++;
    end
    check_val("bp_count", 128'(got), 128'(6));
    set_in(2, 1'b0, '0, '0, 1'b0, 1'b0);
    extra = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (if2.out_valid) extra++;
    end
    check_val("bp_dup", 128'(extra), 128'(0));

    // Reset with two transfers in flight.
    @(negedge clk); set_in(2, 1'b1, 32'hffffffff, 32'h00000002, 1'b0, 1'b0);
    @(negedge clk); set_in(2, 1'b1, 32'h12345678, 32'h00000001, 1'b0, 1'b0);
    @(negedge clk); set_in(2, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check_val("rst_pre", 128'({if2.out_valid, if2.c_out, if2.sum}), 128'({1'b1, 1'b1, 32'h00000001}));
    rst = 1'b1;
    #1;
    check_val("rst_mid", 128'(obs(2)), 128'(0));
    check_val("rst_mid_valid", 128'(if2.out_valid), 128'(0));
    check_val("rst_mid_ready", 128'(if2.in_ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (if2.out_valid) extra++;
    end
    check_val("rst_stale", 128'(extra), 128'(0));

    for (int i = 0; i < 30000 && rnd_done < 3; i++) @(negedge clk);
    check_val("rnd_done", 128'(rnd_done), 128'(3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 32 : 64;
    localparam int S = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    localparam int G = (gi == 0) ? 2 : (gi == 1) ? 4 : 8;
    localparam int N = 3400;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();
    cla_pipe_adder #(.WIDTH(W), .STAGES(S), .GROUP(G)) u_dut (.clk(clk), .rst(rst_rnd), .bus(bus));

    initial begin : drive
      logic [W+1:0] q [$];
      logic [W+1:0] e;
      logic [W+1:0] o;
      logic [63:0]  r;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
      logic         ci;
      logic         sb;
      logic         co;
      logic         ov;
      int           acc;
      int           cyc;
      int           n_extra;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.A = '0; bus.B = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
      acc = 0;
      cyc = 0;
      n_extra = 0;
      wait (rst_rnd == 1'b0);
      while ((acc < N || q.size() != 0) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        r  = {$urandom, $urandom};
        a  = r[W-1:0];
        r  = {$urandom, $urandom};
        b  = r[W-1:0];
        ci = 1'($urandom);
        sb = 1'($urandom);
        // Reference: A - B with borrow test, or A + B + c_in; signed overflow from operand/result signs.
        if (sb) begin
          s  = a - b;
          co = (a >= b);
          ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
          {co, s} = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
          ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
`ifndef CLA_PIPE_OVF_EN
        ov = 1'b0;
`endif
        e = {ov, co, s};
        bus.in_valid  = (acc < N) && ($urandom_range(0, 3) != 0);
        bus.A         = a;
        bus.B         = b;
        bus.c_in      = ci;
        bus.sub       = sb;
        bus.out_ready = ($urandom_range(0, 9) < 7);
        #1;
        if (bus.out_valid && bus.out_ready) begin
          o = {1'b0, bus.c_out, bus.sum};
`ifdef CLA_PIPE_OVF_EN
          o[W+1] = bus.ovf;
`endif
          if (q.size() == 0) n_extra++;
          else check_val($sformatf("rnd_w%0d_s%0d", W, S), 128'(o), 128'(q.pop_front()));
        end
        if (bus.in_valid && bus.in_ready) begin
          q.push_back(e);
          acc++;
        end
      end
      check_val($sformatf("rnd_acc_w%0d", W), 128'(acc), 128'(N));
      check_val($sformatf("rnd_left_w%0d", W), 128'(q.size()), 128'(0));
      check_val($sformatf("rnd_extra_w%0d", W), 128'(n_extra), 128'(0));
      bus.in_valid = 1'b0;
      rnd_done++;
    end
  end
endmodule
